// File: rtl/i3c_xfer_sequencer.sv
// Purpose: sequences one I3C private transfer (START, address byte, N data bytes, optional STOP)
//          and returns one response per descriptor with a status code and a byte count.
// Latency: one command is outstanding at a time; its pulse fires on the first cycle of the state.
// Backpressure: the tx, rx and response streams use valid/ready. A stalled rx byte holds the bus,
//          so no rx_cmd is issued until that byte is taken.
//
// Ports:
//   clk_i, rst_ni                           clock and async active-low reset
//   desc_*                                  descriptor in: addr, rnw, len, stop
//   tx_valid_i/tx_ready_o/tx_data_i         write-data stream in
//   rx_valid_o/rx_ready_i/rx_data_o         read-data stream out
//   abort_i                                 level request for early termination
//   fsm_*_cmd_o, fsm_tx_data_o              command pulses and tx byte to the controller FSM
//   fsm_rx_data_i, fsm_cmd_done_i, fsm_nack_i   completion from the controller FSM
//   resp_valid_o/resp_ready_i/resp_err_o/resp_len_o   response out
//   busy_o                                  high whenever the sequencer is not idle
module i3c_xfer_sequencer #(
    parameter int unsigned LenWidth      = 12,
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                desc_valid_i,
    output logic                desc_ready_o,
    input  logic [6:0]          desc_addr_i,
    input  logic                desc_rnw_i,
    input  logic [LenWidth-1:0] desc_len_i,
    input  logic                desc_stop_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    input  logic [7:0]          tx_data_i,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic [7:0]          rx_data_o,
    input  logic                abort_i,
    output logic                fsm_start_cmd_o,
    output logic                fsm_stop_cmd_o,
    output logic                fsm_tx_cmd_o,
    output logic                fsm_rx_cmd_o,
    output logic [7:0]          fsm_tx_data_o,
    input  logic [7:0]          fsm_rx_data_i,
    input  logic                fsm_cmd_done_i,
    input  logic                fsm_nack_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [2:0]          resp_err_o,
    output logic [LenWidth-1:0] resp_len_o,
    output logic                busy_o
);

    localparam int unsigned TmoW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TmoW-1:0] TmoLast = (TimeoutCycles > 0) ? TmoW'(TimeoutCycles - 1) : '0;

    localparam logic [2:0] ErrAddrNack = 3'd1;
    localparam logic [2:0] ErrDataNack = 3'd2;
    localparam logic [2:0] ErrAborted  = 3'd3;
    localparam logic [2:0] ErrTimeout  = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_TX_FETCH,
        S_TX,
        S_RX,
        S_RX_PUSH,
        S_STOP,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  entry_q, entry_d;
    logic [6:0]            addr_q, addr_d;
    logic                  rnw_q, rnw_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic                  stop_q, stop_d;
    logic [2:0]            err_q, err_d;
    logic [LenWidth-1:0]   cnt_q, cnt_d;
    logic [7:0]            txb_q, txb_d;
    logic [7:0]            rxb_q, rxb_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;

    logic                  cmd_state;
    logic                  done_ok;
    logic                  tmo_hit;
    logic [LenWidth-1:0]   cnt_inc;
    state_e                end_sel;

    assign cmd_state = (state_q == S_START) || (state_q == S_ADDR) || (state_q == S_TX) ||
                       (state_q == S_RX)    || (state_q == S_STOP);
    // The pulse cycle itself cannot carry a completion, so done only counts once waiting.
    assign done_ok   = cmd_state && !entry_q && fsm_cmd_done_i;
    // A done arriving in the expiry cycle takes priority over the timeout.
    assign tmo_hit   = (TimeoutCycles != 0) && cmd_state && (tmo_q == TmoLast) && !fsm_cmd_done_i;
    assign cnt_inc   = cnt_q + 1'b1;
    // Errors always divert to STOP before reaching here, so only the stop flag matters.
    assign end_sel   = stop_q ? S_STOP : S_RESP;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rnw_d           = rnw_q;
        len_d           = len_q;
        stop_d          = stop_q;
        err_d           = err_q;
        cnt_d           = cnt_q;
        txb_d           = txb_q;
        rxb_d           = rxb_q;
        desc_ready_o    = 1'b0;
        tx_ready_o      = 1'b0;
        rx_valid_o      = 1'b0;
        resp_valid_o    = 1'b0;
        fsm_start_cmd_o = 1'b0;
        fsm_stop_cmd_o  = 1'b0;
        fsm_tx_cmd_o    = 1'b0;
        fsm_rx_cmd_o    = 1'b0;
        fsm_tx_data_o   = 8'h00;

        case (state_q)
            S_IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    addr_d  = desc_addr_i;
                    rnw_d   = desc_rnw_i;
                    len_d   = desc_len_i;
                    stop_d  = desc_stop_i;
                    err_d   = '0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                fsm_start_cmd_o = entry_q;
                if (done_ok) begin
                    // An abort seen here skips the address byte entirely.
                    if (abort_i) begin
                        err_d   = ErrAborted;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_ADDR;
                    end
                end else if (tmo_hit) begin
                    err_d   = ErrTimeout;
                    state_d = S_RESP;
                end
            end
            S_ADDR: begin
                fsm_tx_cmd_o  = entry_q;
                fsm_tx_data_o = {addr_q, rnw_q};
                if (done_ok) begin
                    if (fsm_nack_i) begin
                        err_d   = ErrAddrNack;
                        state_d = S_STOP;
                    end else if (abort_i) begin
                        err_d   = ErrAborted;
                        state_d = S_STOP;
                    end else if (len_q == '0) begin
                        state_d = end_sel;
                    end else begin
                        state_d = rnw_q ? S_RX : S_TX_FETCH;
                    end
                end else if (tmo_hit) begin
                    err_d   = ErrTimeout;
                    state_d = S_RESP;
                end
            end
            S_TX_FETCH: begin
                tx_ready_o = 1'b1;
                if (abort_i) begin
                    err_d   = ErrAborted;
                    state_d = S_STOP;
                end else if (tx_valid_i) begin
                    txb_d   = tx_data_i;
                    state_d = S_TX;
                end
            end
            S_TX: begin
                fsm_tx_cmd_o  = entry_q;
                fsm_tx_data_o = txb_q;
                if (done_ok) begin
                    if (fsm_nack_i) begin
                        err_d   = ErrDataNack;
                        state_d = S_STOP;
                    end else begin
                        // The ACKed byte counts even if an abort ends the transfer here.
                        cnt_d = cnt_inc;
                        if (abort_i) begin
                            err_d   = ErrAborted;
                            state_d = S_STOP;
                        end else if (cnt_inc == len_q) begin
                            state_d = end_sel;
                        end else begin
                            state_d = S_TX_FETCH;
                        end
                    end
                end else if (tmo_hit) begin
                    err_d   = ErrTimeout;
                    state_d = S_RESP;
                end
            end
            S_RX: begin
                fsm_rx_cmd_o = entry_q;
                if (done_ok) begin
                    if (abort_i) begin
                        err_d   = ErrAborted;
                        state_d = S_STOP;
                    end else begin
                        rxb_d   = fsm_rx_data_i;
                        state_d = S_RX_PUSH;
                    end
                end else if (tmo_hit) begin
                    err_d   = ErrTimeout;
                    state_d = S_RESP;
                end
            end
            S_RX_PUSH: begin
                rx_valid_o = 1'b1;
                // Abort drops the held byte uncounted, even if it is taken the same cycle.
                if (abort_i) begin
                    err_d   = ErrAborted;
                    state_d = S_STOP;
                end else if (rx_ready_i) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? end_sel : S_RX;
                end
            end
            S_STOP: begin
                fsm_stop_cmd_o = entry_q;
                if (done_ok) begin
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    err_d   = ErrTimeout;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every command state is entered from a different state, so a state change marks entry.
    assign entry_d = (state_d != state_q);

    always_comb begin
        tmo_d = '0;
        if (cmd_state && (state_d == state_q)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            entry_q <= 1'b0;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            len_q   <= '0;
            stop_q  <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
            txb_q   <= '0;
            rxb_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            len_q   <= len_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            txb_q   <= txb_d;
            rxb_q   <= rxb_d;
            tmo_q   <= tmo_d;
        end
    end

    assign rx_data_o  = rxb_q;
    assign resp_err_o = err_q;
    assign resp_len_o = cnt_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: doc/i3c_xfer_sequencer.md
Name: i3c_xfer_sequencer

Overview:
Byte-level transfer sequencer between the active flow FSM and the I3C controller FSM's command/data interface. It takes one private-transfer descriptor (target address, direction, length, stop flag). It then issues START, the address byte, N data-byte commands and an optional STOP. It streams write data in and read data out, and returns one response per descriptor with status and byte count. This is the logic that drives the controller FSM's start/stop/tx/rx command and tx/rx data ports, which are currently tied off.

Parameters:
LenWidth, 12, width of descriptor length and response byte count (max 4095 bytes).
TimeoutCycles, 65535, clk cycles allowed between a command pulse and fsm_cmd_done_i; 0 disables the timeout.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; asynchronous assert, active-low
desc_valid_i / desc_ready_o  in/out  1  descriptor handshake
desc_addr_i  in  7  target dynamic address
desc_rnw_i  in  1  1 = read, 0 = write
desc_len_i  in  LenWidth  data byte count; 0 = address-only
desc_stop_i  in  1  1 = STOP after transfer; 0 = keep bus for repeated START
tx_valid_i / tx_ready_o / tx_data_i  in/out/in  1/1/8  write-data stream
rx_valid_o / rx_ready_i / rx_data_o  out/in/out  1/1/8  read-data stream
abort_i  in  1  level; request early termination
fsm_start_cmd_o, fsm_stop_cmd_o, fsm_tx_cmd_o, fsm_rx_cmd_o  out  1  single-cycle command pulses to the controller FSM
fsm_tx_data_o  out  8  byte for tx_cmd; held stable until done
fsm_rx_data_i  in  8  read byte, valid with fsm_cmd_done_i after rx_cmd
fsm_cmd_done_i  in  1  command-complete pulse
fsm_nack_i  in  1  valid with done after tx_cmd; 1 = target NACKed
resp_valid_o / resp_ready_i  out/in  1  response handshake
resp_err_o  out  3  0 OK, 1 ADDR_NACK, 2 DATA_NACK, 3 ABORTED, 4 TIMEOUT
resp_len_o  out  LenWidth  data bytes completed (ACKed write bytes or delivered read bytes)
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 except desc_ready_o = 1; counters cleared.
- States: IDLE, START, ADDR, TX_FETCH, TX, RX, RX_PUSH, STOP, RESP.
- IDLE: desc_ready_o = 1. On desc_valid_i, latch the descriptor, clear err and count, go to START. desc_ready_o = 0 in all other states.
- Command protocol (START, ADDR, TX, RX, STOP):
  - Exactly one cmd pulse on entry; the state then waits for fsm_cmd_done_i.
  - Only one command is outstanding at any time.
  - fsm_cmd_done_i is ignored when no command is outstanding.
  - Earliest done is 1 cycle after the pulse.
- START: on done, go to ADDR. START is issued for every descriptor; a repeated START after a non-stop transfer is the controller FSM's concern.
- ADDR: fsm_tx_data_o = {addr, rnw}. On done:
  - nack -> err = 1, go to STOP.
  - else if len == 0 -> go to STOP (desc_stop) or RESP.
  - else go to TX_FETCH (write) or RX (read).
- TX_FETCH: tx_ready_o = 1. On tx_valid_i, capture the byte, go to TX. tx_ready_o is 0 in every other state.
- TX: on done:
  - nack -> err = 2, go to STOP; the NACKed byte is not counted.
  - else count++; go to STOP/RESP if count == len, else TX_FETCH.
- RX: on done, capture fsm_rx_data_i, go to RX_PUSH.
- RX_PUSH: rx_valid_o = 1 and rx_data_o stable until rx_ready_i. On handshake, count++, then go to RX or the end. No further rx_cmd is issued while the byte is held (backpressure stalls the bus).
- End selection: go to STOP if desc_stop or err != 0, else RESP. Any error always forces STOP, except TIMEOUT.
- STOP: on done, go to RESP.
- RESP: resp_valid_o = 1; err and count are stable. On resp_ready_i, go to IDLE. The next descriptor is accepted one cycle later at the earliest.
- abort_i:
  - Sampled in ADDR/TX/RX after the outstanding done, and in TX_FETCH/RX_PUSH immediately; the RX_PUSH byte is dropped and not counted.
  - Sets err = 3 (unless already nonzero), then goes to STOP.
  - Ignored in START (wait for done, then abort at the ADDR decision without issuing ADDR), in STOP, in RESP and in IDLE.
- Timeout: a counter runs while a command is outstanding.
  - On reaching TimeoutCycles: err = 4, go directly to RESP with no STOP issued.
  - A late done is ignored.
  - Counter width is clog2(TimeoutCycles + 1).
- Simultaneous done with timeout expiry in the same cycle: done wins.
- Simultaneous nack with abort: NACK code wins.
- resp_len_o never exceeds desc_len. The count is LenWidth wide and does not wrap because it is bounded by len.

Test Plan:
- Write addr=0x52, len=3, stop=1, TX bytes A1 A2 A3, all ACK -> cmds START, tx 0xA4, tx A1, A2, A3, STOP; resp err=0 len=3.
- Read addr=0x10, len=2, stop=1, rx_ready held low 5 cycles on byte 0 -> no second rx_cmd until handshake; rx stream 0x5A, 0xC3; tx byte 0x21; resp err=0 len=2.
- Address NACK on write len=4 -> no data cmds, tx_ready_o never 1, STOP issued; resp err=1 len=0.
- NACK on 2nd data byte of len=4 write -> STOP after byte 2; resp err=2 len=1. Next: len=0 stop=0 -> START, ADDR, no STOP; resp err=0 len=0.
- abort_i asserted in TX_FETCH after 1 byte of len=5 -> STOP; resp err=3 len=1. Then TimeoutCycles=8 with done withheld after START -> resp err=4 exactly 8 cycles after the pulse, no STOP pulse.
- rst_ni asserted while in RX_PUSH -> all outputs 0 and desc_ready_o=1 immediately; after release a fresh descriptor runs normally.
